id_stage: RTL
=============

Name: id_stage

Overview:
Decode stage directly downstream of if_stage. It consumes the fetched instr/pc pair, decodes RV32I fields, reads the register file and produces immediates and control signals. All outputs go through a registered ID/EX boundary toward the execute stage. The block also owns the 32x32 architectural register file, which writeback writes through a dedicated port.

Parameters:
XLEN, 32, datapath and register width
NREGS, 32, number of architectural registers (x0 hardwired to zero)

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
pc_i  input  32  PC of instr_i from if_stage
instr_i  input  32  fetched instruction
valid_i  input  1  instr_i/pc_i valid
stall_i  input  1  hold ID/EX register contents
flush_i  input  1  kill instruction being latched (branch redirect)
wb_we_i  input  1  writeback enable
wb_rd_i  input  5  writeback destination
wb_data_i  input  32  writeback data
valid_o  output  1  ID/EX entry valid
pc_o  output  32  PC of decoded instruction
rs1_o, rs2_o, rd_o  output  5 each  register indices
rs1_data_o, rs2_data_o  output  32 each  operand values
imm_o  output  32  sign-extended immediate
alu_op_o  output  4  alu_op_t encoding
alu_src_imm_o  output  1  ALU B = imm
alu_src_pc_o  output  1  ALU A = pc (AUIPC, JAL, JALR link)
reg_we_o, mem_re_o, mem_we_o, branch_o, jump_o  output  1 each  control
funct3_o  output  3  passed to mem/branch unit
illegal_o  output  1  unsupported opcode

Behaviour:
- Reset (async, rst=1): every output is 0 and every register file entry is 0. Normal operation resumes on the first posedge after rst deasserts.
- Latency: 1 cycle. Outputs reflect the instruction presented at the previous posedge.
- Per posedge, first matching rule wins:
  - flush_i=1: valid_o<=0 and all control outputs <=0. Flush wins over stall.
  - stall_i=1: all outputs hold.
  - Otherwise: latch the decode of instr_i, and valid_o<=valid_i.
  - valid_i=0: control outputs are latched as 0.
- Immediate formats are I/S/B/U/J, sign-extended from bit 31. B and J immediates have bit0=0.
- Supported opcodes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP.
  - Any other opcode: illegal_o=1, and reg_we/mem_re/mem_we/branch/jump are all 0. valid_o still follows valid_i.
- reg_we_o is forced to 0 when rd=0.
- Register file:
  - Reads are combinational.
  - Writes happen on posedge when wb_we_i=1 and wb_rd_i!=0. Writes to x0 are ignored.
  - Writes proceed regardless of stall_i/flush_i.
- Write-first bypass: if wb_we_i=1, wb_rd_i!=0 and wb_rd_i==rs1 (or rs2), the latched operand is wb_data_i instead of the array value. Reads of x0 always return 0.
- No hazard detection inside this block. stall_i/flush_i come from the hazard unit.
- Reset mid-stall or mid-flush: outputs clear immediately; no pending state survives.

Decomposition:
- Shared package radix_pkg:
  - opcode localparams (OPC_LUI=7'b0110111, etc.)
  - alu_op_t enum, 4 bits: ADD=0, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASSB
  - imm_sel_t enum (I, S, B, U, J)
  - XLEN constant
- One sub-module: regfile, which holds the array, write port, two read ports and the bypass. Decode logic and the ID/EX register remain in id_stage.

Test Plan:
- Reset, then pc_i=0x0, instr_i=0x00500093 (addi x1,x0,5), valid_i=1 -> next cycle: valid_o=1, rd_o=1, imm_o=0x5, alu_op_o=ADD, alu_src_imm_o=1, reg_we_o=1, rs1_data_o=0.
- Bypass: wb_we_i=1, wb_rd_i=1, wb_data_i=0xDEADBEEF in the same cycle as instr 0x00108133 (add x2,x1,x1) -> rs1_data_o=rs2_data_o=0xDEADBEEF, alu_op_o=ADD, alu_src_imm_o=0.
- Write x0: wb_rd_i=0, wb_data_i=0x1234, then decode 0x00000093 -> rs1_data_o=0.
- Branch: instr 0xFE000EE3 (beq x0,x0,-4) at pc 0x100 -> imm_o=0xFFFFFFFC, branch_o=1, reg_we_o=0, pc_o=0x100.
- Stall for 3 cycles with a new instr_i on the inputs -> outputs unchanged. Then flush_i=1 together with stall_i=1 -> valid_o=0 and control outputs 0 on the next edge.
- Illegal: instr 0xFFFFFFFF, valid_i=1 -> illegal_o=1, valid_o=1, reg_we_o=mem_we_o=0. Asserting rst mid-cycle -> all outputs 0 before the next edge.

Source files
------------

// File: rtl/radix_pkg.sv
// -----------------------------------------------------------------------------
// radix_pkg
// Purpose : shared definitions for the decode stage and its neighbours.
//           RV32I opcode constants, the ALU operation encoding that execute
//           consumes, the immediate format selector, the decoded control
//           bundle, and helpers that build immediates and pick ALU ops.
// Contents: XLEN, OPC_* opcodes, alu_op_t, imm_sel_t, ctrl_t,
//           gen_imm(), alu_from_funct3()
// -----------------------------------------------------------------------------
package radix_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_t;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } imm_sel_t;

  // Control bundle that crosses the ID/EX boundary. Everything in here is
  // forced to zero for bubbles (invalid or flushed entries).
  typedef struct packed {
    alu_op_t alu_op;
    logic    alu_src_imm;
    logic    alu_src_pc;
    logic    reg_we;
    logic    mem_re;
    logic    mem_we;
    logic    branch;
    logic    jump;
    logic    illegal;
  } ctrl_t;

  // Builds the sign-extended immediate for the requested format. B and J
  // carry an implicit zero in bit 0 because targets are halfword aligned.
  function automatic logic [31:0] gen_imm(input logic [31:0] instr,
                                          input imm_sel_t   sel);
    logic [31:0] imm;
    imm = '0;
    case (sel)
      IMM_I: imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B: imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                    instr[11:8], 1'b0};
      IMM_U: imm = {instr[31:12], 12'h000};
      IMM_J: imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                    instr[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

  // Maps funct3 (plus instr[30]) onto an ALU op for OP and OP-IMM. SUB only
  // exists in the register form; for OP-IMM bit 30 is part of the immediate
  // except on the shift-right encoding where it selects SRA.
  function automatic alu_op_t alu_from_funct3(input logic [2:0] funct3,
                                              input logic       bit30,
                                              input logic       is_imm);
    alu_op_t op;
    op = ALU_ADD;
    case (funct3)
      3'b000: op = (bit30 && !is_imm) ? ALU_SUB : ALU_ADD;
      3'b001: op = ALU_SLL;
      3'b010: op = ALU_SLT;
      3'b011: op = ALU_SLTU;
      3'b100: op = ALU_XOR;
      3'b101: op = bit30 ? ALU_SRA : ALU_SRL;
      3'b110: op = ALU_OR;
      3'b111: op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/id_stage_if.sv
// -----------------------------------------------------------------------------
// id_stage_if
// Purpose : bundles every signal between the decode stage and its
//           neighbours (fetch, hazard unit, writeback, execute).
// Modports: slave  - the decode stage view (fetch/wb/hazard in, ID/EX out)
//           master - the surrounding pipeline view (drives inputs, reads ID/EX)
// -----------------------------------------------------------------------------
interface id_stage_if;
  import radix_pkg::*;

  logic [XLEN-1:0] pc_i;
  logic [31:0]     instr_i;
  logic            valid_i;
  logic            stall_i;
  logic            flush_i;
  logic            wb_we_i;
  logic [4:0]      wb_rd_i;
  logic [XLEN-1:0] wb_data_i;

  logic            valid_o;
  logic [XLEN-1:0] pc_o;
  logic [4:0]      rs1_o;
  logic [4:0]      rs2_o;
  logic [4:0]      rd_o;
  logic [XLEN-1:0] rs1_data_o;
  logic [XLEN-1:0] rs2_data_o;
  logic [XLEN-1:0] imm_o;
  logic [3:0]      alu_op_o;
  logic            alu_src_imm_o;
  logic            alu_src_pc_o;
  logic            reg_we_o;
  logic            mem_re_o;
  logic            mem_we_o;
  logic            branch_o;
  logic            jump_o;
  logic [2:0]      funct3_o;
  logic            illegal_o;

  modport slave (
    input  pc_i, instr_i, valid_i, stall_i, flush_i,
           wb_we_i, wb_rd_i, wb_data_i,
    output valid_o, pc_o, rs1_o, rs2_o, rd_o, rs1_data_o, rs2_data_o,
           imm_o, alu_op_o, alu_src_imm_o, alu_src_pc_o, reg_we_o,
           mem_re_o, mem_we_o, branch_o, jump_o, funct3_o, illegal_o
  );

  modport master (
    output pc_i, instr_i, valid_i, stall_i, flush_i,
           wb_we_i, wb_rd_i, wb_data_i,
    input  valid_o, pc_o, rs1_o, rs2_o, rd_o, rs1_data_o, rs2_data_o,
           imm_o, alu_op_o, alu_src_imm_o, alu_src_pc_o, reg_we_o,
           mem_re_o, mem_we_o, branch_o, jump_o, funct3_o, illegal_o
  );

endinterface

// File: rtl/id_stage_regfile.sv
// -----------------------------------------------------------------------------
// regfile
// Purpose : architectural register file, x0 hardwired to zero. One write
//           port (from writeback) and two combinational read ports with a
//           write-first bypass so an instruction decoded in the same cycle
//           as the producing writeback sees the new value.
// Ports   : clk, rst         - clock, async active-high reset (clears array)
//           wr_en/addr/data  - writeback port, writes to x0 ignored
//           rs1/rs2_addr     - read addresses
//           rs1/rs2_data     - read data (bypassed, x0 reads as 0)
// -----------------------------------------------------------------------------
module regfile
  import radix_pkg::*;
#(
  parameter int XLEN  = radix_pkg::XLEN,
  parameter int NREGS = 32,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data
);

  logic [XLEN-1:0] regs [NREGS];
  logic            wr_live;

  assign wr_live = wr_en && (wr_addr != '0);

  // Write port. Entry 0 is never written so it stays at its reset value of
  // zero; the read path also masks it so x0 never depends on array contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_live) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Read ports with write-first bypass: a live write to the same register
  // wins over the stored value.
  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    if (rs1_addr != '0) begin
      rs1_data = (wr_live && (wr_addr == rs1_addr)) ? wr_data : regs[rs1_addr];
    end
    if (rs2_addr != '0) begin
      rs2_data = (wr_live && (wr_addr == rs2_addr)) ? wr_data : regs[rs2_addr];
    end
  end

endmodule

// File: rtl/id_stage.sv
// -----------------------------------------------------------------------------
// id_stage
// Purpose : RV32I decode stage. Splits the fetched instruction into register
//           indices, funct3 and a sign-extended immediate, derives the
//           execute control bundle, reads operands from the owned register
//           file and registers everything at the ID/EX boundary.
// Ports   : clk, rst - clock, async active-high reset
//           bus      - id_stage_if.slave: fetch inputs (pc_i, instr_i,
//                      valid_i), hazard controls (stall_i, flush_i),
//                      writeback port (wb_*), and all ID/EX outputs
// Priority at each edge: flush clears the entry, else stall holds it, else
// the new decode is latched. Bubbles (valid_i=0) carry an all-zero control
// bundle so nothing downstream can act on them.
// -----------------------------------------------------------------------------
module id_stage
  import radix_pkg::*;
#(
  parameter int XLEN  = radix_pkg::XLEN,
  parameter int NREGS = 32
) (
  input logic       clk,
  input logic       rst,
  id_stage_if.slave bus
);

  logic [6:0]      opcode;
  logic [4:0]      rs1_f;
  logic [4:0]      rs2_f;
  logic [4:0]      rd_f;
  logic [2:0]      funct3_f;

  ctrl_t           dec;
  ctrl_t           dec_gated;
  imm_sel_t        imm_sel;
  logic            has_imm;
  logic [31:0]     imm_d;
  logic [XLEN-1:0] rs1_rd;
  logic [XLEN-1:0] rs2_rd;

  logic            valid_q;
  logic [XLEN-1:0] pc_q;
  logic [4:0]      rs1_q;
  logic [4:0]      rs2_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] rs1_data_q;
  logic [XLEN-1:0] rs2_data_q;
  logic [XLEN-1:0] imm_q;
  logic [2:0]      funct3_q;
  ctrl_t           ctrl_q;

  assign opcode   = bus.instr_i[6:0];
  assign rd_f     = bus.instr_i[11:7];
  assign funct3_f = bus.instr_i[14:12];
  assign rs1_f    = bus.instr_i[19:15];
  assign rs2_f    = bus.instr_i[24:20];

  regfile #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (bus.wb_we_i),
    .wr_addr  (bus.wb_rd_i),
    .wr_data  (bus.wb_data_i),
    .rs1_addr (rs1_f),
    .rs2_addr (rs2_f),
    .rs1_data (rs1_rd),
    .rs2_data (rs2_rd)
  );

  // Opcode decode. Jumps put the PC on ALU A so execute can form the link
  // address; branches use SUB for the comparison. Unknown opcodes raise
  // illegal with every side-effecting control left at zero and no immediate.
  always_comb begin
    dec     = '0;
    imm_sel = IMM_I;
    has_imm = 1'b0;
    case (opcode)
      OPC_LUI: begin
        dec.alu_op      = ALU_PASSB;
        dec.alu_src_imm = 1'b1;
        dec.reg_we      = 1'b1;
        imm_sel         = IMM_U;
        has_imm         = 1'b1;
      end
      OPC_AUIPC: begin
        dec.alu_op      = ALU_ADD;
        dec.alu_src_imm = 1'b1;
        dec.alu_src_pc  = 1'b1;
        dec.reg_we      = 1'b1;
        imm_sel         = IMM_U;
        has_imm         = 1'b1;
      end
      OPC_JAL: begin
        dec.alu_op      = ALU_ADD;
        dec.alu_src_pc  = 1'b1;
        dec.reg_we      = 1'b1;
        dec.jump        = 1'b1;
        imm_sel         = IMM_J;
        has_imm         = 1'b1;
      end
      OPC_JALR: begin
        dec.alu_op      = ALU_ADD;
        dec.alu_src_pc  = 1'b1;
        dec.reg_we      = 1'b1;
        dec.jump        = 1'b1;
        imm_sel         = IMM_I;
        has_imm         = 1'b1;
      end
      OPC_BRANCH: begin
        dec.alu_op      = ALU_SUB;
        dec.branch      = 1'b1;
        imm_sel         = IMM_B;
        has_imm         = 1'b1;
      end
      OPC_LOAD: begin
        dec.alu_op      = ALU_ADD;
        dec.alu_src_imm = 1'b1;
        dec.mem_re      = 1'b1;
        dec.reg_we      = 1'b1;
        imm_sel         = IMM_I;
        has_imm         = 1'b1;
      end
      OPC_STORE: begin
        dec.alu_op      = ALU_ADD;
        dec.alu_src_imm = 1'b1;
        dec.mem_we      = 1'b1;
        imm_sel         = IMM_S;
        has_imm         = 1'b1;
      end
      OPC_OPIMM: begin
        dec.alu_op      = alu_from_funct3(funct3_f, bus.instr_i[30], 1'b1);
        dec.alu_src_imm = 1'b1;
        dec.reg_we      = 1'b1;
        imm_sel         = IMM_I;
        has_imm         = 1'b1;
      end
      OPC_OP: begin
        dec.alu_op      = alu_from_funct3(funct3_f, bus.instr_i[30], 1'b0);
        dec.reg_we      = 1'b1;
      end
      default: begin
        dec.illegal     = 1'b1;
      end
    endcase
    if (rd_f == 5'd0) begin
      dec.reg_we = 1'b0;
    end
  end

  // Bubbles carry no control so a stale or garbage instruction word on the
  // fetch bus cannot trigger writes, memory accesses or redirects.
  always_comb begin
    dec_gated = '0;
    if (bus.valid_i) begin
      dec_gated = dec;
    end
    imm_d = has_imm ? gen_imm(bus.instr_i, imm_sel) : 32'h0;
  end

  // ID/EX boundary register. Flush takes priority over stall and clears the
  // whole entry; stall holds it; otherwise the fresh decode is captured.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      funct3_q   <= '0;
      ctrl_q     <= '0;
    end else if (bus.flush_i) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      funct3_q   <= '0;
      ctrl_q     <= '0;
    end else if (!bus.stall_i) begin
      valid_q    <= bus.valid_i;
      pc_q       <= bus.pc_i;
      rs1_q      <= rs1_f;
      rs2_q      <= rs2_f;
      rd_q       <= rd_f;
      rs1_data_q <= rs1_rd;
      rs2_data_q <= rs2_rd;
      imm_q      <= imm_d;
      funct3_q   <= funct3_f;
      ctrl_q     <= dec_gated;
    end
  end

  assign bus.valid_o       = valid_q;
  assign bus.pc_o          = pc_q;
  assign bus.rs1_o         = rs1_q;
  assign bus.rs2_o         = rs2_q;
  assign bus.rd_o          = rd_q;
  assign bus.rs1_data_o    = rs1_data_q;
  assign bus.rs2_data_o    = rs2_data_q;
  assign bus.imm_o         = imm_q;
  assign bus.funct3_o      = funct3_q;
  assign bus.alu_op_o      = ctrl_q.alu_op;
  assign bus.alu_src_imm_o = ctrl_q.alu_src_imm;
  assign bus.alu_src_pc_o  = ctrl_q.alu_src_pc;
  assign bus.reg_we_o      = ctrl_q.reg_we;
  assign bus.mem_re_o      = ctrl_q.mem_re;
  assign bus.mem_we_o      = ctrl_q.mem_we;
  assign bus.branch_o      = ctrl_q.branch;
  assign bus.jump_o        = ctrl_q.jump;
  assign bus.illegal_o     = ctrl_q.illegal;

endmodule
